// File: rtl/kt_pkg.sv
// Shared types and constants for the UART command wrapper and its serial engine.
// Holds the command-assembly state enum, the serial FSM enums and the default bit period.
package kt_pkg;

  localparam int BAUD_DIV_DEFAULT = 5208;
  localparam int FRAME_LAST_BIT   = 9;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_BUSY = 1'b1
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  // 8N1 frame as sent on the wire, LSB first: start(0), D0..D7, stop(1).
  function automatic logic [9:0] frameBits(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart.sv
// Bit-level 8N1 serial engine: synchronized receiver delivering rx_rdy/rx_data pulses
// and an independent transmitter started by trmt and reporting tx_done.
module uart
  import kt_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  // The edge is seen one clock after sync2 falls, so the half-bit load is two short.
  localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV / 2 - 2);
  localparam logic [15:0] FULL_LOAD = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(FRAME_LAST_BIT);

  logic        r_rxSync1;
  logic        r_rxSync2;
  logic        r_rxPrev;
  rx_state_t   r_rxState;
  rx_state_t   w_rxNext;
  logic [15:0] r_rxCnt;
  logic [3:0]  r_rxBitIdx;
  logic [7:0]  r_rxShift;
  logic        r_rxRdy;
  logic [7:0]  r_rxData;
  logic        w_rxFall;
  logic        w_rxTick;
  logic        w_rxStartBad;
  logic        w_rxStopTick;

  tx_state_t   r_txState;
  tx_state_t   w_txNext;
  logic [9:0]  r_txShift;
  logic [15:0] r_txCnt;
  logic [3:0]  r_txBitIdx;
  logic        r_txDone;
  logic        w_txBitEnd;

  // Sync flops preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
      r_rxPrev  <= 1'b1;
    end else begin
      r_rxSync1 <= RX;
      r_rxSync2 <= r_rxSync1;
      r_rxPrev  <= r_rxSync2;
    end
  end

  assign w_rxFall     = r_rxPrev & ~r_rxSync2;
  assign w_rxTick     = (r_rxState == RX_BUSY) && (r_rxCnt == 16'd0);
  assign w_rxStartBad = w_rxTick && (r_rxBitIdx == 4'd0) && r_rxSync2;
  assign w_rxStopTick = w_rxTick && (r_rxBitIdx == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rxState <= RX_IDLE;
    else        r_rxState <= w_rxNext;
  end

  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      RX_IDLE: if (w_rxFall) w_rxNext = RX_BUSY;
      RX_BUSY: if (w_rxStartBad || w_rxStopTick) w_rxNext = RX_IDLE;
      default: w_rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxCnt    <= 16'd0;
      r_rxBitIdx <= 4'd0;
      r_rxShift  <= 8'd0;
      r_rxRdy    <= 1'b0;
      r_rxData   <= 8'd0;
    end else begin
      r_rxRdy <= 1'b0;
      if (r_rxState == RX_IDLE) begin
        if (w_rxFall) begin
          r_rxCnt    <= HALF_LOAD;
          r_rxBitIdx <= 4'd0;
        end
      end else if (w_rxTick) begin
        r_rxCnt    <= FULL_LOAD;
        r_rxBitIdx <= r_rxBitIdx + 4'd1;
        if ((r_rxBitIdx != 4'd0) && (r_rxBitIdx != LAST_BIT))
          r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
        if (w_rxStopTick && r_rxSync2) begin
          r_rxRdy  <= 1'b1;
          r_rxData <= r_rxShift;
        end
      end else begin
        r_rxCnt <= r_rxCnt - 16'd1;
      end
    end
  end

  assign rx_rdy  = r_rxRdy;
  assign rx_data = r_rxData;

  assign w_txBitEnd = (r_txState == TX_BUSY) && (r_txCnt == FULL_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_txState <= TX_IDLE;
    else        r_txState <= w_txNext;
  end

  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      TX_IDLE: if (trmt) w_txNext = TX_BUSY;
      TX_BUSY: if (w_txBitEnd && (r_txBitIdx == LAST_BIT)) w_txNext = TX_IDLE;
      default: w_txNext = TX_IDLE;
    endcase
  end

  // trmt is only looked at while idle, so a request mid-frame simply falls away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txShift  <= 10'h3FF;
      r_txCnt    <= 16'd0;
      r_txBitIdx <= 4'd0;
      r_txDone   <= 1'b0;
    end else if (r_txState == TX_IDLE) begin
      if (trmt) begin
        r_txShift  <= frameBits(tx_data);
        r_txCnt    <= 16'd0;
        r_txBitIdx <= 4'd0;
        r_txDone   <= 1'b0;
      end
    end else if (w_txBitEnd) begin
      r_txCnt <= 16'd0;
      if (r_txBitIdx == LAST_BIT) begin
        r_txDone <= 1'b1;
      end else begin
        r_txShift  <= {1'b1, r_txShift[9:1]};
        r_txBitIdx <= r_txBitIdx + 4'd1;
      end
    end else begin
      r_txCnt <= r_txCnt + 16'd1;
    end
  end

  assign TX      = (r_txState == TX_BUSY) ? r_txShift[0] : 1'b1;
  assign tx_done = r_txDone;

endmodule

// File: rtl/uart_wrapper.sv
// Command front end: pairs received bytes into a 16-bit command with a ready flag,
// and forwards response bytes to the serial transmitter.
module uart_wrapper
  import kt_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  logic       w_rxRdy;
  logic [7:0] w_rxData;
  asm_state_t r_state;
  asm_state_t w_nextState;
  logic [7:0]  r_highByte;
  logic [15:0] r_cmd;
  logic        r_cmdRdy;

  uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .trmt    (trmt),
    .tx_data (resp),
    .TX      (TX),
    .tx_done (tx_done),
    .rx_rdy  (w_rxRdy),
    .rx_data (w_rxData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_HI;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_rxRdy) begin
      case (r_state)
        WAIT_HI: w_nextState = WAIT_LO;
        WAIT_LO: w_nextState = WAIT_HI;
        default: w_nextState = WAIT_HI;
      endcase
    end
  end

  // A set from a completed pair overrides a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_highByte <= 8'd0;
      r_cmd      <= 16'd0;
      r_cmdRdy   <= 1'b0;
    end else begin
      if (clr_cmd_rdy) r_cmdRdy <= 1'b0;
      if (w_rxRdy) begin
        if (r_state == WAIT_HI) begin
          r_highByte <= w_rxData;
          r_cmdRdy   <= 1'b0;
        end else begin
          r_cmd    <= {r_highByte, w_rxData};
          r_cmdRdy <= 1'b1;
        end
      end
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmdRdy;

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed self-checking bench for uart_wrapper: command assembly, acknowledge,
// response framing, framing errors, start-glitch rejection, mid-frame reset and full duplex.
module tb_uart_wrapper;
  import kt_pkg::*;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [9:0] expFrame;
  logic [9:0] rxFrame;

  uart_wrapper #(
    .BAUD_DIV(BD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .trmt        (trmt),
    .resp        (resp),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input logic [9:0] frame, input int nBits);
    for (int i = 0; i < nBits; i++) begin
      RX = frame[i];
      waitEdges(BD);
    end
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    sendBits({stopBit, data, 1'b0}, 10);
  endtask

  task automatic pulseClr();
    clr_cmd_rdy = 1'b1;
    waitEdges(1);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulseTrmt(input logic [7:0] data);
    resp = data;
    trmt = 1'b1;
    waitEdges(1);
    trmt = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    trmt        = 1'b0;
    resp        = 8'h00;
    expFrame    = 10'b1101001010;
    waitEdges(2);

    // Reset values
    checkOutput("rst_TX", {15'd0, TX}, 16'd1);
    checkOutput("rst_cmd", cmd, 16'h0000);
    checkOutput("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    checkOutput("rst_tx_done", {15'd0, tx_done}, 16'd0);
    rst_n = 1'b1;
    waitEdges(2);

    // Command assembly 0x40, 0x02 with exact ready latency
    sendFrame(8'h40, 1'b1);
    checkOutput("asm_hi_rdy", {15'd0, cmd_rdy}, 16'd0);
    checkOutput("asm_hi_cmd", cmd, 16'h0000);
    sendBits({1'b1, 8'h02, 1'b0}, 9);
    RX = 1'b1;
    waitEdges(10);
    checkOutput("asm_stop_sample_rdy", {15'd0, cmd_rdy}, 16'd0);
    waitEdges(1);
    checkOutput("asm_rdy", {15'd0, cmd_rdy}, 16'd1);
    checkOutput("asm_cmd", cmd, 16'h4002);
    waitEdges(BD - 11);

    // Acknowledge, then acknowledge colliding with a set
    pulseClr();
    checkOutput("clr_rdy", {15'd0, cmd_rdy}, 16'd0);
    checkOutput("clr_cmd_hold", cmd, 16'h4002);
    sendFrame(8'h5B, 1'b1);
    sendBits({1'b1, 8'hF1, 1'b0}, 9);
    RX = 1'b1;
    waitEdges(10);
    clr_cmd_rdy = 1'b1;
    waitEdges(1);
    clr_cmd_rdy = 1'b0;
    checkOutput("set_wins_rdy", {15'd0, cmd_rdy}, 16'd1);
    checkOutput("set_wins_cmd", cmd, 16'h5BF1);
    waitEdges(BD - 11);
    pulseClr();
    checkOutput("clr2_rdy", {15'd0, cmd_rdy}, 16'd0);

    // Response framing of 0xA5 with an ignored trmt during bit 3
    pulseTrmt(8'hA5);
    checkOutput("tx_start_done", {15'd0, tx_done}, 16'd0);
    waitEdges(7);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("tx_bit%0d", k), {15'd0, TX}, {15'd0, expFrame[k]});
      if (k == 3) begin
        resp = 8'h00;
        trmt = 1'b1;
        waitEdges(1);
        trmt = 1'b0;
        checkOutput("tx_busy_trmt_done", {15'd0, tx_done}, 16'd0);
        waitEdges(BD - 1);
      end else if (k < 9) begin
        waitEdges(BD);
      end
    end
    waitEdges(8);
    checkOutput("tx_stop_end_done", {15'd0, tx_done}, 16'd0);
    waitEdges(1);
    checkOutput("tx_done", {15'd0, tx_done}, 16'd1);
    checkOutput("tx_idle", {15'd0, TX}, 16'd1);

    // Framing error discards the byte without advancing assembly
    sendFrame(8'h47, 1'b0);
    RX = 1'b1;
    waitEdges(4);
    checkOutput("ferr_rdy", {15'd0, cmd_rdy}, 16'd0);
    checkOutput("ferr_cmd", cmd, 16'h5BF1);
    sendFrame(8'h47, 1'b1);
    checkOutput("ferr_hi_rdy", {15'd0, cmd_rdy}, 16'd0);
    sendFrame(8'hF1, 1'b1);
    checkOutput("ferr_cmd_pair", cmd, 16'h47F1);
    checkOutput("ferr_rdy_pair", {15'd0, cmd_rdy}, 16'd1);

    // Short low glitch is rejected at the start-bit sample
    RX = 1'b0;
    waitEdges(3);
    RX = 1'b1;
    waitEdges(20);
    checkOutput("glitch_rdy", {15'd0, cmd_rdy}, 16'd1);
    sendFrame(8'h12, 1'b1);
    checkOutput("glitch_hi_rdy", {15'd0, cmd_rdy}, 16'd0);
    sendFrame(8'h34, 1'b1);
    checkOutput("glitch_cmd", cmd, 16'h1234);

    // Reset during a received high byte and a transmit frame
    pulseTrmt(8'hA5);
    checkOutput("trmt_clears_done", {15'd0, tx_done}, 16'd0);
    rxFrame = {1'b1, 8'h53, 1'b0};
    sendBits(rxFrame, 5);
    RX = rxFrame[5];
    waitEdges(8);
    checkOutput("pre_rst_TX", {15'd0, TX}, {15'd0, expFrame[5]});
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_TX", {15'd0, TX}, 16'd1);
    checkOutput("mid_rst_rdy", {15'd0, cmd_rdy}, 16'd0);
    checkOutput("mid_rst_cmd", cmd, 16'h0000);
    checkOutput("mid_rst_state", {15'd0, dut.r_state}, {15'd0, WAIT_HI});
    waitEdges(1);
    rst_n = 1'b1;
    RX    = 1'b1;
    waitEdges(3 * BD);
    checkOutput("post_rst_TX", {15'd0, TX}, 16'd1);
    checkOutput("post_rst_done", {15'd0, tx_done}, 16'd0);
    sendFrame(8'h53, 1'b1);
    sendFrame(8'hF2, 1'b1);
    checkOutput("post_rst_cmd", cmd, 16'h53F2);
    checkOutput("post_rst_rdy", {15'd0, cmd_rdy}, 16'd1);
    pulseClr();

    // Full duplex: transmit 0xA5 while receiving 0x40, 0x02
    pulseTrmt(8'hA5);
    rxFrame = {1'b1, 8'h40, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RX = rxFrame[k];
      waitEdges(BD / 2);
      checkOutput($sformatf("fd_tx_bit%0d", k), {15'd0, TX}, {15'd0, expFrame[k]});
      waitEdges(BD / 2);
    end
    checkOutput("fd_tx_done", {15'd0, tx_done}, 16'd1);
    checkOutput("fd_TX_idle", {15'd0, TX}, 16'd1);
    sendFrame(8'h02, 1'b1);
    checkOutput("fd_cmd", cmd, 16'h4002);
    checkOutput("fd_rdy", {15'd0, cmd_rdy}, 16'd1);
    checkOutput("fd_done_hold", {15'd0, tx_done}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
